pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Physical-memory responder for the cache-to-memory line interface: the target that services pmem_read/pmem_write from an L1 cache controller and answers with pmem_resp.
- Holds a line-granular backing store and returns or accepts one full cache line per transaction after a programmable latency.
- Used as the memory endpoint behind the I-cache and D-cache in simulation and on FPGA, and as the lower-level port model for future L2 work.

Parameters:
- LINE_BITS, 256, width of one cache line (pmem_rdata/pmem_wdata).
- IDX_BITS, 10, number of line-index bits; the store holds 2**IDX_BITS lines.
- LATENCY, 8, cycles from request acceptance to pmem_resp; legal range 1..255.
- OFFSET_BITS, 5, low address bits ignored, which is log2(LINE_BITS/8).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pmem_address  in  32  byte address of the line; bits [OFFSET_BITS-1:0] are ignored.
- pmem_read  in  1  read request level; the initiator holds it until pmem_resp or abandons it.
- pmem_write  in  1  write request level; same hold rule as pmem_read.
- pmem_wdata  in  LINE_BITS  write line; sampled at the acceptance edge.
- pmem_rdata  out  LINE_BITS  read line; valid in the pmem_resp cycle and held until the next read response.
- pmem_resp  out  1  single-cycle completion pulse.
- protocol_err  out  1  single-cycle pulse when pmem_read and pmem_write are both high while IDLE samples.

Behaviour:
- Reset (reset=0, asynchronous)
  - state becomes IDLE; pmem_resp, protocol_err and pmem_rdata become 0; the counter becomes 0.
  - Store contents are not reset.
  - Reset during BUSY or RESP abandons the transaction: no resp, no write.
- States
  - IDLE: samples the request. If pmem_read or pmem_write is high at an edge, latch the index (pmem_address[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS]), the operation and wdata. Load count=LATENCY-1 and go to BUSY, or go directly to RESP when LATENCY=1.
  - BUSY: decrement count each edge. When count=0, go to RESP.
  - RESP: pmem_resp=1 for exactly one cycle.
    - Read: pmem_rdata is the registered store[index].
    - Write: the store is updated at the edge leaving RESP.
    - Next state is RECOVER.
  - RECOVER: one dead cycle with requests ignored, then IDLE. This covers an initiator that drops its request one cycle after the resp edge.
- Latency: request first high at edge N gives pmem_resp high in the cycle after edge N+LATENCY-1, i.e. exactly LATENCY cycles after acceptance. Minimum turnaround between back-to-back transactions is LATENCY+2 cycles.
- Abort: if the latched operation's request line is low at any edge in BUSY, go to IDLE. No resp is issued and no write occurs. Abort is not checked in RESP; a resp cycle always completes.
- Simultaneous read and write while IDLE samples: the read is serviced, the write is ignored, and protocol_err pulses in the following cycle.
- Address: upper bits above the index are ignored, so addresses alias modulo 2**(IDX_BITS+OFFSET_BITS). The address is latched at acceptance; changes during BUSY are ignored.
- Write-then-read to the same line returns the new data. The store write commits before RECOVER ends.
- pmem_rdata is not changed by write transactions.

Decomposition:
- Package pmem_pkg
  - constants LINE_BITS_DEF=256 and OFFSET_BITS_DEF=5.
  - typedef pmem_line_t (logic [255:0]).
  - enum pmem_state_t {IDLE, BUSY, RESP, RECOVER}.
- Sub-module pmem_line_array: single-port synchronous line store with registered read and write enable. The top-level FSM and counter live in pmem_line_responder.

Test Plan:
- Reset held low mid-BUSY, released -> pmem_resp=0, pmem_rdata=0, state IDLE; a following read of an unwritten index completes after LATENCY cycles with no hang.
- Write addr 0x0000_0040 with data 0xA5 repeated for 256 bits, LATENCY=8 -> pmem_resp in exactly the 8th cycle after acceptance, one cycle wide; a subsequent read of 0x0000_0040 returns 0xA5 pattern.
- Read 0x0000_005F after the above -> same line returned (offset bits ignored); read 0x0000_8040 with IDX_BITS=10 -> aliases to the same line.
- Read issued, pmem_read dropped in the 3rd BUSY cycle -> no pmem_resp, IDLE; a write aborted the same way -> the line is unchanged on readback.
- pmem_read and pmem_write both high at IDLE -> read serviced, protocol_err single pulse, store unchanged.
- Back-to-back reads with pmem_read held continuously -> the second resp arrives LATENCY+2 cycles after the first resp; LATENCY=1 -> resp in the cycle after acceptance.

Source files
------------

// File: rtl/pmem_pkg.sv
`default_nettype none
//============================================================================
// pmem_pkg -- shared types and defaults for the pmem line responder. Rev 1.0
//============================================================================
package pmem_pkg;

  localparam int LINE_BITS_DEF   = 256;
  localparam int OFFSET_BITS_DEF = 5;

  typedef logic [255:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } pmem_state_t;

endpackage
`default_nettype wire

// File: rtl/pmem_line_array.sv
`default_nettype none
//============================================================================
// pmem_line_array -- single-port line store, registered read. Rev 1.0
//============================================================================
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int IDX_BITS  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  addr,
  input  logic [LINE_BITS-1:0] wdata,
  output logic [LINE_BITS-1:0] rdata
);

  localparam int c_DEPTH = 1 << IDX_BITS;

  logic [LINE_BITS-1:0] r_mem [c_DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rdata <= '0;
    else if (rd_en) rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/pmem_line_responder.sv
`default_nettype none
//============================================================================
// pmem_line_responder -- line memory target with programmable latency. Rev 1.0
//============================================================================
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int LINE_BITS   = LINE_BITS_DEF,
  parameter int IDX_BITS    = 10,
  parameter int LATENCY     = 8,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pmem_address,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 protocol_err
);

  localparam logic [7:0] c_LOAD      = 8'(LATENCY - 1);
  localparam bit         c_ONE_CYCLE = (LATENCY == 1);

  pmem_state_t          r_state;
  pmem_state_t          w_next_state;
  logic [7:0]           r_count;
  logic [IDX_BITS-1:0]  r_index;
  logic                 r_is_write;
  logic [LINE_BITS-1:0] r_wdata;
  logic                 r_protocol_err;

  logic [IDX_BITS-1:0]  w_req_index;
  logic [IDX_BITS-1:0]  w_arr_addr;
  logic                 w_req;
  logic                 w_held;
  logic                 w_op_read;
  logic                 w_rd_en;
  logic                 w_wr_en;
  logic                 w_unused_addr;

  assign w_req         = pmem_read | pmem_write;
  assign w_req_index   = pmem_address[OFFSET_BITS +: IDX_BITS];
  assign w_held        = r_is_write ? pmem_write : pmem_read;
  assign w_unused_addr = ^pmem_address;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Abort has priority over the terminal count in BUSY.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next_state = c_ONE_CYCLE ? RESP : BUSY;
      BUSY: begin
        if (!w_held)              w_next_state = IDLE;
        else if (r_count <= 8'd1) w_next_state = RESP;
      end
      RESP:    w_next_state = RECOVER;
      RECOVER: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Read data is fetched on the edge entering RESP; the write commits leaving it.
  always_comb begin
    pmem_resp  = 1'b0;
    w_wr_en    = 1'b0;
    w_op_read  = (r_state == IDLE) ? pmem_read : ~r_is_write;
    w_rd_en    = (w_next_state == RESP) && (r_state != RESP) && w_op_read;
    w_arr_addr = (r_state == IDLE) ? w_req_index : r_index;
    if (r_state == RESP) begin
      pmem_resp = 1'b1;
      w_wr_en   = r_is_write;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count        <= '0;
      r_index        <= '0;
      r_is_write     <= 1'b0;
      r_wdata        <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_protocol_err <= (r_state == IDLE) && pmem_read && pmem_write;
      if (r_state == IDLE && w_req) begin
        r_index    <= w_req_index;
        r_is_write <= ~pmem_read;
        r_wdata    <= pmem_wdata;
        r_count    <= c_LOAD;
      end else if (r_state == BUSY) begin
        r_count <= r_count - 8'd1;
      end
    end
  end

  assign protocol_err = r_protocol_err;

  pmem_line_array #(
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .rd_en (w_rd_en),
    .wr_en (w_wr_en),
    .addr  (w_arr_addr),
    .wdata (r_wdata),
    .rdata (pmem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_responder.sv
`default_nettype none
//============================================================================
// tb_pmem_line_responder -- random/directed bench with a line-level model. Rev 1.0
//============================================================================
module tb_pmem_line_responder;

  localparam int LB   = 256;
  localparam int LAT0 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [31:0]   addr  [2];
  logic          rd    [2];
  logic          wr    [2];
  logic [LB-1:0] wd    [2];
  logic [LB-1:0] rdata [2];
  logic          resp  [2];
  logic          perr  [2];

  pmem_line_responder #(.LINE_BITS(LB), .IDX_BITS(10), .LATENCY(LAT0), .OFFSET_BITS(5)) u_dut (
    .clk(clk), .reset(reset), .pmem_address(addr[0]), .pmem_read(rd[0]), .pmem_write(wr[0]),
    .pmem_wdata(wd[0]), .pmem_rdata(rdata[0]), .pmem_resp(resp[0]), .protocol_err(perr[0]));

  pmem_line_responder #(.LINE_BITS(LB), .IDX_BITS(10), .LATENCY(1), .OFFSET_BITS(5)) u_dut_l1 (
    .clk(clk), .reset(reset), .pmem_address(addr[1]), .pmem_read(rd[1]), .pmem_write(wr[1]),
    .pmem_wdata(wd[1]), .pmem_rdata(rdata[1]), .pmem_resp(resp[1]), .protocol_err(perr[1]));

  // Reference model: one line array per DUT plus the last returned read line.
  logic [LB-1:0] mem     [2][1024];
  bit            valid   [2][1024];
  logic [LB-1:0] last_rd [2];
  bit            rd_known[2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? LAT0 : 1;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32) % 1024);
  endfunction

  function automatic logic [LB-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction on DUT d; abort_k>0 drops the request after the k-th post-acceptance cycle.
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [LB-1:0] data, input int abort_k, input string tag);
    int L, first, pulses, perr_cnt, idx;
    bit perr_c1, done;
    logic [LB-1:0] rd_seen;
    L = lat(d); first = 0; pulses = 0; perr_cnt = 0; perr_c1 = 0;
    idx = idx_of(a); rd_seen = '0; done = (abort_k == 0);
    addr[d] = a; rd[d] = r; wr[d] = w; wd[d] = data;
    for (int c = 1; c <= L + 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        addr[d] = $urandom;
        wd[d]   = rand_line();
      end
      if (resp[d]) begin
        pulses++;
        if (first == 0) begin
          first = c; rd_seen = rdata[d]; rd[d] = 1'b0; wr[d] = 1'b0;
        end
      end
      if (perr[d]) begin
        perr_cnt++;
        if (c == 1) perr_c1 = 1'b1;
      end
      if (abort_k != 0 && c == abort_k) begin
        rd[d] = 1'b0; wr[d] = 1'b0;
      end
    end
    check({tag, " resp_cycle"}, first, done ? L : 0);
    check({tag, " resp_pulses"}, pulses, done ? 1 : 0);
    check({tag, " perr_cycle1"}, perr_c1, r && w);
    check({tag, " perr_pulses"}, perr_cnt, (r && w) ? 1 : 0);
    if (done && r) begin
      if (valid[d][idx]) begin
        check({tag, " rdata"}, rd_seen, mem[d][idx]);
        last_rd[d] = mem[d][idx]; rd_known[d] = 1'b1;
      end else begin
        rd_known[d] = 1'b0;
      end
    end else if (done && w) begin
      if (rd_known[d]) check({tag, " rdata_hold_on_write"}, rd_seen, last_rd[d]);
      mem[d][idx] = data; valid[d][idx] = 1'b1;
    end else if (rd_known[d]) begin
      check({tag, " rdata_hold_on_abort"}, rdata[d], last_rd[d]);
    end
  endtask

  // Start a DUT0 transaction, pull reset low in its third cycle, and confirm it is abandoned.
  task automatic reset_mid(input bit r, input bit w, input logic [31:0] a, input logic [LB-1:0] data);
    int pulses;
    pulses = 0;
    addr[0] = a; rd[0] = r; wr[0] = w; wd[0] = data;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rstmid resp", resp[0], 1'b0);
    check("rstmid rdata", rdata[0], '0);
    check("rstmid rdata_l1", rdata[1], '0);
    @(negedge clk);
    rd[0] = 1'b0; wr[0] = 1'b0; reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp[0]) pulses++;
    end
    check("rstmid no_resp", pulses, 0);
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0; rd_known[d] = 1'b1;
    end
  endtask

  task automatic back_to_back(input logic [31:0] a);
    int t1, t2, idx;
    t1 = 0; t2 = 0; idx = idx_of(a);
    addr[0] = a; rd[0] = 1'b1; wr[0] = 1'b0;
    for (int c = 1; c <= 3 * LAT0 + 8 && t2 == 0; c++) begin
      @(posedge clk); #1;
      if (resp[0]) begin
        if (t1 == 0) t1 = c;
        else         t2 = c;
      end
    end
    rd[0] = 1'b0;
    check("b2b first_resp", t1, LAT0);
    check("b2b gap", t2 - t1, LAT0 + 2);
    if (valid[0][idx]) begin
      check("b2b rdata", rdata[0], mem[0][idx]);
      last_rd[0] = mem[0][idx]; rd_known[0] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [LB-1:0] a5_line, line_a, line_b;
  logic [31:0]   ra;
  int            op, k;
  bit            r, w;

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; wd[d] = '0;
      last_rd[d] = '0; rd_known[d] = 1'b1;
      for (int i = 0; i < 1024; i++) valid[d][i] = 1'b0;
    end
    a5_line = {32{8'hA5}};
    repeat (3) @(posedge clk);
    #1;
    check("reset resp", resp[0], 1'b0);
    check("reset perr", perr[0], 1'b0);
    check("reset rdata", rdata[0], '0);
    check("reset resp_l1", resp[1], 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Reset mid-read, then an unwritten line must still complete.
    reset_mid(1'b1, 1'b0, 32'h0000_0040, '0);
    txn(0, 1'b1, 1'b0, 32'h0000_6000, '0, 0, "unwritten_read");

    // A write abandoned by reset must leave the line intact.
    line_a = rand_line();
    txn(0, 1'b0, 1'b1, 32'h0000_0080, line_a, 0, "wr80");
    reset_mid(1'b0, 1'b1, 32'h0000_0080, ~line_a);
    txn(0, 1'b1, 1'b0, 32'h0000_0080, '0, 0, "rd80_after_rst");

    txn(0, 1'b0, 1'b1, 32'h0000_0040, a5_line, 0, "wr40_a5");
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, "rd40");
    txn(0, 1'b1, 1'b0, 32'h0000_005F, '0, 0, "rd5F_offset");
    txn(0, 1'b1, 1'b0, 32'h0000_8040, '0, 0, "rd8040_alias");

    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 3, "abort_read");
    txn(0, 1'b0, 1'b1, 32'h0000_0040, ~a5_line, 3, "abort_write");
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, "rd40_after_abort");

    line_b = rand_line();
    txn(0, 1'b1, 1'b1, 32'h0000_0040, line_b, 0, "both_high");
    txn(0, 1'b1, 1'b0, 32'h0000_0040, '0, 0, "rd40_after_both");

    back_to_back(32'h0000_0040);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      r  = (op < 5) || (op == 9);
      w  = (op >= 5);
      ra = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      k  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, LAT0 - 1) : 0;
      txn(0, r, w, ra, rand_line(), k, "rand_l8");
    end

    for (int i = 0; i < 16; i++) begin
      op = $urandom_range(0, 9);
      r  = (op < 5) || (op == 9);
      w  = (op >= 5);
      ra = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 3)) << 5) | 32'($urandom_range(0, 31));
      txn(1, r, w, ra, rand_line(), 0, "rand_l1");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
